// File: rtl/fetch_exec_sequencer.sv
// Multi-cycle fetch/decode/execute control sequencer for the instruction memory and register file datapath.
// Every output is a register that changes on the same edge as the state it belongs to.
module fetch_exec_sequencer #(
  parameter logic [31:0] PC_STEP      = 32'd4,
  parameter int unsigned COUNT_W      = 16,
  parameter int unsigned EXEC_TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               halt_req,
  input  logic [31:0]        pc_in,
  input  logic [31:0]        inst_in,
  input  logic               alu_done,
  output logic               rd_pc,
  output logic               rd_inst,
  output logic               rd_1,
  output logic               rd_2,
  output logic               rd_3,
  output logic               wr_reg_file,
  output logic               wr_pc,
  output logic [31:0]        pc_next,
  output logic [31:0]        inst_latched,
  output logic               busy,
  output logic               err,
  output logic [2:0]         state,
  output logic [COUNT_W-1:0] instr_count
);

  localparam int unsigned TO_W = $clog2(EXEC_TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_PC_RD  = 3'd1,
    S_FETCH  = 3'd2,
    S_REG_RD = 3'd3,
    S_EXEC   = 3'd4,
    S_WB     = 3'd5,
    S_PC_WR  = 3'd6,
    S_HALT   = 3'd7
  } state_t;

  state_t             state_q, state_d;
  logic [31:0]        pc_reg_q, pc_next_q, inst_q;
  logic [TO_W-1:0]    to_q;
  logic [COUNT_W-1:0] cnt_q;
  logic               err_q, busy_q;
  logic               rd_pc_q, rd_inst_q, rd_1_q, rd_2_q, rd_3_q, wr_reg_q, wr_pc_q;
  logic               writes_dest, timeout_hit;

  // MOV and MVN take no first source operand.
  function automatic logic dec_rd1(input logic [31:0] inst);
    return !(inst[24:21] == 4'b1101 || inst[24:21] == 4'b1111);
  endfunction

  // Compare/test opcodes 1000..1011 update flags only and never write a destination.
  assign writes_dest = (inst_q[27:26] == 2'b00) && (inst_q[24:22] != 3'b100) &&
                       (inst_q[24:21] != 4'b1010) && (inst_q[24:21] != 4'b1011);
  assign timeout_hit = (to_q == TO_W'(EXEC_TIMEOUT - 1));

  // Next-state decode.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_HALT: if (start) state_d = S_PC_RD;
      S_PC_RD:        state_d = S_FETCH;
      S_FETCH:        state_d = S_REG_RD;
      S_REG_RD:       state_d = S_EXEC;
      S_EXEC: begin
        if (alu_done)         state_d = writes_dest ? S_WB : S_PC_WR;
        else if (timeout_hit) state_d = S_HALT;
      end
      S_WB:           state_d = S_PC_WR;
      S_PC_WR:        state_d = halt_req ? S_HALT : S_PC_RD;
      default:        state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      pc_reg_q  <= '0;
      pc_next_q <= '0;
      inst_q    <= '0;
      to_q      <= '0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
      rd_pc_q   <= 1'b0;
      rd_inst_q <= 1'b0;
      rd_1_q    <= 1'b0;
      rd_2_q    <= 1'b0;
      rd_3_q    <= 1'b0;
      wr_reg_q  <= 1'b0;
      wr_pc_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == S_PC_RD) pc_reg_q <= pc_in;
      if (state_q == S_FETCH) inst_q   <= inst_in;
      if (state_q == S_REG_RD)                 to_q <= '0;
      else if (state_q == S_EXEC && !alu_done) to_q <= to_q + TO_W'(1);
      if (state_q == S_EXEC && !alu_done && timeout_hit) err_q <= 1'b1;
      if (state_d == S_PC_WR) pc_next_q <= pc_reg_q + PC_STEP;
      if (state_q == S_PC_WR) cnt_q <= cnt_q + COUNT_W'(1);
      busy_q    <= (state_d != S_IDLE) && (state_d != S_HALT);
      rd_pc_q   <= (state_d == S_PC_RD);
      rd_inst_q <= (state_d == S_FETCH);
      // Source strobes decode the word being captured on this same edge.
      rd_1_q    <= (state_d == S_REG_RD) && dec_rd1(inst_in);
      rd_2_q    <= (state_d == S_REG_RD) && !inst_in[25];
      rd_3_q    <= (state_d == S_REG_RD) && !inst_in[25] && inst_in[4];
      wr_reg_q  <= (state_d == S_WB);
      wr_pc_q   <= (state_d == S_PC_WR);
    end
  end

  assign rd_pc        = rd_pc_q;
  assign rd_inst      = rd_inst_q;
  assign rd_1         = rd_1_q;
  assign rd_2         = rd_2_q;
  assign rd_3         = rd_3_q;
  assign wr_reg_file  = wr_reg_q;
  assign wr_pc        = wr_pc_q;
  assign pc_next      = pc_next_q;
  assign inst_latched = inst_q;
  assign busy         = busy_q;
  assign err          = err_q;
  assign state        = state_q;
  assign instr_count  = cnt_q;

endmodule

// File: tb/tb_fetch_exec_sequencer.sv
// Directed bench for fetch_exec_sequencer: per-cycle vector table plus hand-written handshake sequences.
module tb_fetch_exec_sequencer;

  localparam logic [31:0] ADD = 32'hE0812003;
  localparam logic [31:0] CMP = 32'hE1510002;
  localparam logic [31:0] MOV = 32'hE1A01312;
  // Strobe vector order: {rd_pc, rd_inst, rd_1, rd_2, rd_3, wr_reg_file, wr_pc}
  localparam logic [6:0] B0 = 7'b0000000, BPC = 7'b1000000, BIN = 7'b0100000,
                         B12 = 7'b0011000, B23 = 7'b0001100, BWB = 7'b0000010,
                         BWP = 7'b0000001;

  logic        clk = 1'b0;
  logic        rst_n, start, halt_req, alu_done;
  logic [31:0] pc_in, inst_in;
  logic        rd_pc, rd_inst, rd_1, rd_2, rd_3, wr_reg_file, wr_pc, busy, err;
  logic [31:0] pc_next, inst_latched;
  logic [2:0]  state;
  logic [15:0] instr_count;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic        rst_n, start, halt, alu;
    logic [31:0] pc, inst;
    logic [2:0]  st;
    logic [6:0]  strb;
    logic        err;
    logic [15:0] cnt;
    logic [31:0] pcn;
  } vec_t;

  vec_t vq[$];

  fetch_exec_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .halt_req(halt_req),
    .pc_in(pc_in), .inst_in(inst_in), .alu_done(alu_done),
    .rd_pc(rd_pc), .rd_inst(rd_inst), .rd_1(rd_1), .rd_2(rd_2), .rd_3(rd_3),
    .wr_reg_file(wr_reg_file), .wr_pc(wr_pc), .pc_next(pc_next),
    .inst_latched(inst_latched), .busy(busy), .err(err), .state(state),
    .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic r, input logic s, input logic h, input logic a,
                      input logic [31:0] pc, input logic [31:0] inst, input logic [2:0] st,
                      input logic [6:0] strb, input logic e, input logic [15:0] c,
                      input logic [31:0] pcn);
    vec_t v;
    v.rst_n = r; v.start = s; v.halt = h; v.alu = a; v.pc = pc; v.inst = inst;
    v.st = st; v.strb = strb; v.err = e; v.cnt = c; v.pcn = pcn;
    vq.push_back(v);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Strobe exclusivity, and source strobes only in REG_RD, on every cycle out of reset.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      chk("strobe_onehot", 32'({rd_pc, rd_inst, wr_reg_file, wr_pc} & ({rd_pc, rd_inst, wr_reg_file, wr_pc} - 4'd1)), 32'd0);
      if (state !== 3'd3) chk("src_outside_regrd", 32'({rd_1, rd_2, rd_3}), 32'd0);
    end
  end

  initial begin
    int n;
    bit seen;
    rst_n = 1'b0; start = 1'b0; halt_req = 1'b0; alu_done = 1'b0;
    pc_in = '0; inst_in = '0;

    // ADD with writeback
    push(0,0,0,0, 32'h0,  32'h0, 3'd0, B0,  0, 16'd0, 32'h0);
    push(1,1,0,0, 32'h10, ADD,   3'd1, BPC, 0, 16'd0, 32'h0);
    push(1,0,0,0, 32'h10, ADD,   3'd2, BIN, 0, 16'd0, 32'h0);
    push(1,0,0,0, 32'h10, ADD,   3'd3, B12, 0, 16'd0, 32'h0);
    push(1,0,0,1, 32'h10, ADD,   3'd4, B0,  0, 16'd0, 32'h0);
    push(1,0,0,1, 32'h10, ADD,   3'd5, BWB, 0, 16'd0, 32'h0);
    push(1,0,0,0, 32'h10, ADD,   3'd6, BWP, 0, 16'd0, 32'h14);
    // CMP skips WB; start mid-instruction is ignored
    push(1,0,0,0, 32'h14, CMP,   3'd1, BPC, 0, 16'd1, 32'h14);
    push(1,0,0,0, 32'h14, CMP,   3'd2, BIN, 0, 16'd1, 32'h14);
    push(1,1,0,0, 32'h14, CMP,   3'd3, B12, 0, 16'd1, 32'h14);
    push(1,0,0,1, 32'h14, CMP,   3'd4, B0,  0, 16'd1, 32'h14);
    push(1,0,0,1, 32'h14, CMP,   3'd6, BWP, 0, 16'd1, 32'h18);
    // MOV reg-shift; halt_req during FETCH is ignored
    push(1,0,0,0, 32'h18, MOV,   3'd1, BPC, 0, 16'd2, 32'h18);
    push(1,0,0,0, 32'h18, MOV,   3'd2, BIN, 0, 16'd2, 32'h18);
    push(1,0,1,0, 32'h18, MOV,   3'd3, B23, 0, 16'd2, 32'h18);
    push(1,0,0,1, 32'h18, MOV,   3'd4, B0,  0, 16'd2, 32'h18);
    push(1,0,0,1, 32'h18, MOV,   3'd5, BWB, 0, 16'd2, 32'h18);
    push(1,0,0,0, 32'h18, MOV,   3'd6, BWP, 0, 16'd2, 32'h1C);
    // PC wrap, then halt_req in PC_WR
    push(1,0,0,0, 32'hFFFFFFFC, CMP, 3'd1, BPC, 0, 16'd3, 32'h1C);
    push(1,0,0,0, 32'hFFFFFFFC, CMP, 3'd2, BIN, 0, 16'd3, 32'h1C);
    push(1,0,0,0, 32'hFFFFFFFC, CMP, 3'd3, B12, 0, 16'd3, 32'h1C);
    push(1,0,0,1, 32'hFFFFFFFC, CMP, 3'd4, B0,  0, 16'd3, 32'h1C);
    push(1,0,0,1, 32'hFFFFFFFC, CMP, 3'd6, BWP, 0, 16'd3, 32'h0);
    push(1,0,1,0, 32'h40, ADD,   3'd7, B0,  0, 16'd4, 32'h0);
    push(1,0,1,0, 32'h40, ADD,   3'd7, B0,  0, 16'd4, 32'h0);
    // Resume from HALT, then EXEC timeout
    push(1,1,0,0, 32'h40, ADD,   3'd1, BPC, 0, 16'd4, 32'h0);
    push(1,0,0,0, 32'h40, ADD,   3'd2, BIN, 0, 16'd4, 32'h0);
    push(1,0,0,0, 32'h40, ADD,   3'd3, B12, 0, 16'd4, 32'h0);
    push(1,0,0,0, 32'h40, ADD,   3'd4, B0,  0, 16'd4, 32'h0);
    for (int k = 0; k < 14; k++)
      push(1,0,0,0, 32'h40, ADD, 3'd4, B0,  0, 16'd4, 32'h0);
    push(1,0,0,0, 32'h40, ADD,   3'd7, B0,  1, 16'd4, 32'h0);
    // Restart with err sticky, then reset mid-EXEC
    push(1,1,0,0, 32'h40, ADD,   3'd1, BPC, 1, 16'd4, 32'h0);
    push(1,0,0,0, 32'h40, ADD,   3'd2, BIN, 1, 16'd4, 32'h0);
    push(1,0,0,0, 32'h40, ADD,   3'd3, B12, 1, 16'd4, 32'h0);
    push(1,0,0,0, 32'h40, ADD,   3'd4, B0,  1, 16'd4, 32'h0);
    push(0,0,0,1, 32'h40, ADD,   3'd0, B0,  0, 16'd0, 32'h0);

    for (int i = 0; i < vq.size(); i++) begin
      rst_n = vq[i].rst_n; start = vq[i].start; halt_req = vq[i].halt;
      alu_done = vq[i].alu; pc_in = vq[i].pc; inst_in = vq[i].inst;
      tick();
      chk($sformatf("v%0d_state", i), 32'(state), 32'(vq[i].st));
      chk($sformatf("v%0d_strobes", i),
          32'({rd_pc, rd_inst, rd_1, rd_2, rd_3, wr_reg_file, wr_pc}), 32'(vq[i].strb));
      chk($sformatf("v%0d_busy", i), 32'(busy), 32'(vq[i].st != 3'd0 && vq[i].st != 3'd7));
      chk($sformatf("v%0d_err", i), 32'(err), 32'(vq[i].err));
      chk($sformatf("v%0d_count", i), 32'(instr_count), 32'(vq[i].cnt));
      chk($sformatf("v%0d_pc_next", i), pc_next, vq[i].pcn);
    end

    // Handshake: alu_done delayed, bounded waits on EXEC and wr_pc.
    rst_n = 1'b1; start = 1'b1; pc_in = 32'h100; inst_in = ADD; alu_done = 1'b0; halt_req = 1'b0;
    tick();
    start = 1'b0;
    n = 0;
    while (state !== 3'd4 && n < 10) begin tick(); n++; end
    chk("wait_exec_bound", 32'(state), 32'd4);
    chk("inst_latched", inst_latched, ADD);
    repeat (3) tick();
    chk("exec_hold", 32'(state), 32'd4);
    alu_done = 1'b1;
    halt_req = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      tick();
      if (wr_pc === 1'b1) seen = 1'b1;
    end
    chk("wait_wr_pc_bound", 32'(seen), 32'd1);
    chk("hs_pc_next", pc_next, 32'h104);
    alu_done = 1'b0;
    tick();
    chk("hs_halt_state", 32'(state), 32'd7);
    chk("hs_busy", 32'(busy), 32'd0);
    chk("hs_count", 32'(instr_count), 32'd1);
    chk("hs_err", 32'(err), 32'd0);
    halt_req = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
